// File: rtl/pipeline_to_pulse_credited.sv
// Ready/valid wrapper around a pulse-driven module with no backpressure.
// An input is accepted only when a credit guarantees room in the output FIFO
// for its result, so the module may return results at any time without loss.
module pipeline_to_pulse_credited #(
  parameter int unsigned IN_WIDTH     = 8,
  parameter int unsigned OUT_WIDTH    = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MIN_INTERVAL = 1
) (
  input  logic                         i_clock,
  input  logic                         i_clear_n,
  input  logic                         i_valid_in,
  output logic                         o_ready_in,
  input  logic [IN_WIDTH-1:0]          i_data_in,
  output logic                         o_valid_out,
  input  logic                         i_ready_out,
  output logic [OUT_WIDTH-1:0]         o_data_out,
  output logic                         o_module_pulse_in,
  output logic [IN_WIDTH-1:0]          o_module_data_in,
  input  logic                         i_module_pulse_out,
  input  logic [OUT_WIDTH-1:0]         i_module_data_out,
  output logic [$clog2(DEPTH+1)-1:0]   o_outstanding,
  output logic                         o_error
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned INT_W = (MIN_INTERVAL > 1) ? $clog2(MIN_INTERVAL) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [INT_W-1:0] INT_LOAD = INT_W'(MIN_INTERVAL - 1);

  // Credits cover both results still inside the module and results buffered here.
  logic [CNT_W-1:0]     r_credits;
  logic [CNT_W-1:0]     r_count;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [INT_W-1:0]     r_interval;
  logic                 r_error;
  logic [OUT_WIDTH-1:0] r_mem [DEPTH];

  logic             w_ready_in;
  logic             w_in_done;
  logic             w_valid_out;
  logic             w_out_done;
  logic [CNT_W-1:0] w_in_flight;
  logic             w_spurious;
  logic             w_write;

  // Pointer advance with explicit wrap so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode; ready_in depends only on registered state and reset.
  always_comb begin
    w_valid_out = (r_count != '0);
    w_ready_in  = i_clear_n & (r_credits < DEPTH_C) & (r_interval == '0);
    w_in_done   = i_valid_in & w_ready_in;
    w_out_done  = w_valid_out & i_ready_out;
    w_in_flight = r_credits - r_count;
    // A result with nothing in flight cannot belong to any accepted input.
    w_spurious  = i_module_pulse_out & (w_in_flight == '0);
    w_write     = i_module_pulse_out & ~w_spurious;
  end

  // Credit counter: +1 per accepted input, -1 per delivered output.
  always_ff @(posedge i_clock or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_credits <= '0;
    end else if (w_in_done && !w_out_done) begin
      r_credits <= r_credits + CNT_W'(1);
    end else if (!w_in_done && w_out_done) begin
      r_credits <= r_credits - CNT_W'(1);
    end
  end

  // FIFO occupancy: +1 per accepted result, -1 per pop.
  always_ff @(posedge i_clock or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_count <= '0;
    end else if (w_write && !w_out_done) begin
      r_count <= r_count + CNT_W'(1);
    end else if (!w_write && w_out_done) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // FIFO pointers and storage; the head is reset so data_out reads 0 out of reset.
  always_ff @(posedge i_clock or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_write) begin
        r_mem[r_wr_ptr] <= i_module_data_out;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_out_done) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end
  end

  // Initiation-interval counter: reload on each start pulse, count down to 0.
  always_ff @(posedge i_clock or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_interval <= '0;
    end else if (w_in_done) begin
      r_interval <= INT_LOAD;
    end else if (r_interval != '0) begin
      r_interval <= r_interval - INT_W'(1);
    end
  end

  // Sticky error flag for unexpected result pulses.
  always_ff @(posedge i_clock or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_error <= 1'b0;
    end else if (w_spurious) begin
      r_error <= 1'b1;
    end
  end

  assign o_ready_in        = w_ready_in;
  assign o_module_pulse_in = w_in_done;
  assign o_module_data_in  = i_data_in;
  assign o_valid_out       = w_valid_out;
  assign o_data_out        = r_mem[r_rd_ptr];
  assign o_outstanding     = r_credits;
  assign o_error           = r_error;

endmodule
